// File: rtl/gray_timer_sched.sv
// Round-robin (or fixed-priority) scheduler sharing one gray_timer among NREQ requesters.
// Optional feature macro: GRAY_SCHED_RR_EN selects round-robin; undefined gives lowest-index priority.
module gray_timer_sched #(
  parameter int SIZE = 8,
  parameter int NREQ = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*SIZE-1:0] LimitBus,
  output logic [NREQ-1:0]      Gnt,
  output logic [NREQ-1:0]      Done,
  output logic                 Busy,
  output logic                 TmrRst_n,
  output logic [SIZE-1:0]      TmrLimit,
  input  logic                 TmrInt
);

  // state | meaning
  // IDLE  | no job; timer held cleared; arbitrate pending requests
  // ARM   | winner granted, its limit loaded, timer still held cleared
  // RUN   | timer counting; wait for TmrInt or loss of Req
  // DONE  | one-cycle Done pulse to the winner, timer cleared again

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0]   NREQ_W = NREQ[IW:0];
  localparam logic [IW-1:0] LAST   = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx, gidx_nxt;
  logic [IW-1:0]   win;
  logic            found;
  logic [IW:0]     sum;
  logic [NREQ-1:0] gnt_nxt, done_nxt;
  logic [SIZE-1:0] lim_nxt;

  // Search from ptr upward, wrapping modulo NREQ; first pending requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + k[IW:0];
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && Req[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end

`ifdef GRAY_SCHED_RR_EN
  logic [IW-1:0] ptr_nxt;

  assign ptr_nxt = (gidx == LAST) ? '0 : gidx + IW'(1);

  // Pointer moves past the winner whenever its job ends, by completion or abort.
  always_ff @(posedge Clk) begin
    if (Rst)
      ptr <= '0;
    else if (state != IDLE && state_nxt == IDLE)
      ptr <= ptr_nxt;
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      Gnt      <= '0;
      Done     <= '0;
      TmrLimit <= '0;
      gidx     <= '0;
    end else begin
      state    <= state_nxt;
      Gnt      <= gnt_nxt;
      Done     <= done_nxt;
      TmrLimit <= lim_nxt;
      gidx     <= gidx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = Gnt;
    done_nxt  = '0;
    lim_nxt   = TmrLimit;
    gidx_nxt  = gidx;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (found) begin
          gnt_nxt[win] = 1'b1;
          gidx_nxt     = win;
          lim_nxt      = LimitBus[win*SIZE +: SIZE];
          state_nxt    = ARM;
        end
      end
      ARM: begin
        if (!Req[gidx]) begin
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!Req[gidx]) begin
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (TmrInt) begin
          done_nxt[gidx] = 1'b1;
          state_nxt      = DONE;
        end
      end
      DONE: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign Busy     = (state != IDLE);
  assign TmrRst_n = (state == RUN);

endmodule

// File: tb/tb_gray_timer_sched.sv
// Directed bench for gray_timer_sched with a behavioural Gray-timer stand-in.
// Expected grant order follows GRAY_SCHED_RR_EN when the bench is built with it.
module tb_gray_timer_sched;

  localparam int SIZE = 8;
  localparam int NREQ = 4;

  logic             Clk;
  logic             Rst;
  logic [NREQ-1:0]  Req;
  logic [31:0]      LimitBus;
  logic [NREQ-1:0]  Gnt;
  logic [NREQ-1:0]  Done;
  logic             Busy;
  logic             TmrRst_n;
  logic [SIZE-1:0]  TmrLimit;
  logic             TmrInt;

  int n_cmp  = 0;
  int n_fail = 0;

  gray_timer_sched #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Req      (Req),
    .LimitBus (LimitBus),
    .Gnt      (Gnt),
    .Done     (Done),
    .Busy     (Busy),
    .TmrRst_n (TmrRst_n),
    .TmrLimit (TmrLimit),
    .TmrInt   (TmrInt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Timer stand-in: cleared while TmrRst_n low, counts up, sticky Int once count equals limit.
  logic [SIZE-1:0] t_cnt;
  logic            t_int;
  always @(posedge Clk) begin
    if (!TmrRst_n) begin
      t_cnt <= '0;
      t_int <= 1'b0;
    end else if (t_cnt == TmrLimit) begin
      t_int <= 1'b1;
    end else begin
      t_cnt <= t_cnt + 8'd1;
    end
  end
  assign TmrInt = t_int;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps until Done is nonzero; cycle number relative to grant, or -1 on timeout.
  task automatic wait_done(input int start, input int max, output int cyc, output logic [NREQ-1:0] val);
    int c;
    bit f;
    c = start;
    f = 1'b0;
    while (!f && c <= max) begin
      if (Done !== '0) f = 1'b1;
      else begin
        step();
        c++;
      end
    end
    cyc = f ? c : -1;
    val = Done;
  endtask

  int              cyc;
  logic [NREQ-1:0] dv;
  int              exp_g[5];
  logic [NREQ-1:0] onehot;

  initial begin
`ifdef GRAY_SCHED_RR_EN
    exp_g = '{0, 1, 2, 3, 0};
`else
    exp_g = '{0, 0, 0, 0, 0};
`endif
    Rst      = 1'b1;
    Req      = 4'b1111;
    LimitBus = '0;
    repeat (3) step();
    chk("rst_gnt",     32'(Gnt), 0);
    chk("rst_done",    32'(Done), 0);
    chk("rst_busy",    32'(Busy), 0);
    chk("rst_tmrrstn", 32'(TmrRst_n), 0);
    chk("rst_limit",   32'(TmrLimit), 0);
    Req = '0;
    Rst = 1'b0;
    step();
    chk("idle_busy", 32'(Busy), 0);

    // Single job on requester 2, limit 5; later LimitBus change must not matter.
    LimitBus[16 +: 8] = 8'd5;
    Req = 4'b0100;
    step();
    chk("single_gnt",     32'(Gnt), 32'h4);
    chk("single_limit",   32'(TmrLimit), 5);
    chk("single_arm_rst", 32'(TmrRst_n), 0);
    chk("single_busy",    32'(Busy), 1);
    step();
    chk("single_run_rst", 32'(TmrRst_n), 1);
    LimitBus[16 +: 8] = 8'd99;
    wait_done(1, 20, cyc, dv);
    chk("single_done_cyc", 32'(cyc), 8);
    chk("single_done_val", 32'(dv), 32'h4);
    chk("single_done_gnt", 32'(Gnt), 32'h4);
    Req = '0;
    step();
    chk("single_end_gnt",   32'(Gnt), 0);
    chk("single_end_busy",  32'(Busy), 0);
    chk("single_end_limit", 32'(TmrLimit), 5);

    // Limit 0 on requester 0.
    LimitBus[0 +: 8] = 8'd0;
    Req = 4'b0001;
    step();
    chk("l0_gnt", 32'(Gnt), 32'h1);
    wait_done(0, 20, cyc, dv);
    chk("l0_done_cyc", 32'(cyc), 3);
    chk("l0_done_val", 32'(dv), 32'h1);
    Req = '0;
    step();

    // Limit 255 on requester 3.
    LimitBus[24 +: 8] = 8'd255;
    Req = 4'b1000;
    step();
    chk("l255_gnt", 32'(Gnt), 32'h8);
    wait_done(0, 300, cyc, dv);
    chk("l255_done_cyc", 32'(cyc), 258);
    chk("l255_done_val", 32'(dv), 32'h8);
    Req = '0;
    step();

    // Contention: all requesters pending, all limits 3.
    LimitBus = 32'h03030303;
    Req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      onehot = 4'b0001 << exp_g[i];
      chk($sformatf("cont_gnt%0d", i), 32'(Gnt), 32'(onehot));
      wait_done(0, 20, cyc, dv);
      chk($sformatf("cont_done_cyc%0d", i), 32'(cyc), 6);
      chk($sformatf("cont_done_val%0d", i), 32'(dv), 32'(onehot));
      if (i == 4) Req = '0;
      step();
      chk($sformatf("cont_gap%0d", i), 32'(Gnt), 0);
      if (i < 4) step();
    end

    // Abort: requester 1 (limit 10) drops Req in RUN cycle 3; requester 2 next.
    LimitBus[8 +: 8]  = 8'd10;
    LimitBus[16 +: 8] = 8'd3;
    Req = 4'b0110;
    step();
    chk("abort_gnt", 32'(Gnt), 32'h2);
    step();
    step();
    step();
    chk("abort_run_busy", 32'(Busy), 1);
    Req = 4'b0100;
    step();
    chk("abort_gnt_clr", 32'(Gnt), 0);
    chk("abort_no_done", 32'(Done), 0);
    step();
    chk("abort_next_gnt", 32'(Gnt), 32'h4);
    wait_done(0, 20, cyc, dv);
    chk("abort_next_cyc", 32'(cyc), 6);
    chk("abort_next_val", 32'(dv), 32'h4);
    Req = '0;
    step();

    // Reset in cycle 4 of a limit-20 job, then a fresh all-pending request.
    LimitBus[16 +: 8] = 8'd20;
    Req = 4'b0100;
    step();
    chk("mrst_gnt", 32'(Gnt), 32'h4);
    repeat (4) step();
    Rst = 1'b1;
    step();
    chk("mrst_gnt_clr", 32'(Gnt), 0);
    chk("mrst_busy",    32'(Busy), 0);
    chk("mrst_done",    32'(Done), 0);
    chk("mrst_tmrrstn", 32'(TmrRst_n), 0);
    chk("mrst_limit",   32'(TmrLimit), 0);
    Rst = 1'b0;
    LimitBus[0 +: 8] = 8'd3;
    Req = 4'b1111;
    step();
    chk("mrst_fresh_gnt", 32'(Gnt), 32'h1);
    wait_done(0, 20, cyc, dv);
    chk("mrst_fresh_cyc", 32'(cyc), 6);
    chk("mrst_fresh_val", 32'(dv), 32'h1);
    Req = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
